// File: rtl/psum_pkg.sv
// Shared types and constants for the partial-sum accumulator.
// Optional rounding before the scale shift is enabled with ROUND_EN.
package psum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int ADC_W_D = 4;
    localparam int NBITS_D = 4;
    localparam int ACC_W   = ADC_W_D + NBITS_D + 1;
    localparam int RELU_W  = 6;
    localparam int SAT_W   = 32;
    localparam int OUT_MAX = 31;
    localparam int OUT_MIN = -32;

    typedef struct packed {
        logic [RELU_W-1:0] val;
        logic              sat;
    } sat_t;

    // Clip a wide signed value into the ReLU range and report clipping.
    // Callers sign-extend their sum to SAT_W so any accumulator width fits.
    function automatic sat_t sat_clip(input logic signed [SAT_W-1:0] x);
        sat_t r;
        if (x > OUT_MAX) begin
            r.val = RELU_W'(OUT_MAX);
            r.sat = 1'b1;
        end else if (x < OUT_MIN) begin
            r.val = RELU_W'(OUT_MIN);
            r.sat = 1'b1;
        end else begin
            r.val = x[RELU_W-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_sat_shift.sv
// Combinational scale (arithmetic right shift) and saturate of a final sum.
// ROUND_EN adds half an LSB before the shift (round half up) when SHIFT>0.
module psum_sat_shift
    import psum_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int SHIFT = 0
) (
    input  logic [IN_W-1:0]   sum,
    output logic [RELU_W-1:0] res,
    output logic              sat
);

`ifdef ROUND_EN
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
`endif

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shifted;
    sat_t                 clip;

    // one guard bit keeps the rounding add from overflowing
    always_comb begin
        ext = {sum[IN_W-1], sum};
`ifdef ROUND_EN
        rnd = (SHIFT > 0) ? ((IN_W+1)'(1) << RS) : '0;
`else
        rnd = '0;
`endif
        shifted = (ext + rnd) >>> SHIFT;
        clip    = sat_clip(SAT_W'(shifted));
        res     = clip.val;
        sat     = clip.sat;
    end

endmodule

// File: rtl/psum_accumulator.sv
// Shift-add accumulator of bit-serial ADC partial sums feeding the ReLU.
// Build option ROUND_EN selects round-half-up scaling in psum_sat_shift.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int ADC_W = ADC_W_D,
    parameter int NBITS = NBITS_D,
    parameter int SHIFT = 0,
    parameter int OUT_W = RELU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [ADC_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             sat_flag,
    output logic             busy
);

    localparam int AW = ADC_W + NBITS + 1;
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        beat_cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sx;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] final_sum;
    logic                 fire;
    logic                 last_beat;
    logic [RELU_W-1:0]    res;
    logic                 res_sat;

    assign fire      = in_valid & in_ready & ~clear;
    assign last_beat = (beat_cnt == LAST);
    assign busy      = (beat_cnt != '0);

    // weighted term for this bit plane; the MSB plane has negative weight
    always_comb begin
        sx        = AW'(signed'(in_data));
        term      = sx <<< beat_cnt;
        final_sum = last_beat ? (acc - term) : (acc + term);
    end

    psum_sat_shift #(
        .IN_W  (AW),
        .SHIFT (SHIFT)
    ) u_sat (
        .sum (final_sum),
        .res (res),
        .sat (res_sat)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: finish a frame into HOLD, leave on consumer handshake
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACC;
        end else begin
            unique case (state)
                ACC:  if (fire && last_beat) state_nxt = HOLD;
                HOLD: if (out_ready)         state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    // handshake outputs follow the state directly
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
    end

    // accumulator, beat counter and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            beat_cnt <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
        end else if (fire) begin
            if (last_beat) begin
                acc      <= '0;
                beat_cnt <= '0;
                out_data <= OUT_W'(res);
                sat_flag <= res_sat;
            end else begin
                acc      <= final_sum;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator (SHIFT=0 main DUT, SHIFT=1 aux).
// Expected values come from a sum-of-weighted-planes reference model.
module tb_psum_accumulator;

`ifdef ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_data;
    logic       sat_flag;
    logic       busy;

    logic       v1 = 1'b0;
    logic [3:0] d1 = '0;
    logic       ir1;
    logic       ov1;
    logic       or1 = 1'b0;
    logic [5:0] od1;
    logic       sf1;
    logic       bz1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.ADC_W(4), .NBITS(4), .SHIFT(0), .OUT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .busy(busy)
    );

    psum_accumulator #(.ADC_W(4), .NBITS(4), .SHIFT(1), .OUT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .in_valid(v1), .in_data(d1), .in_ready(ir1),
        .out_valid(ov1), .out_ready(or1),
        .out_data(od1), .sat_flag(sf1), .busy(bz1)
    );

    // beats packed with beat 0 in bits [3:0]; returns {sat, value}
    function automatic logic [6:0] model(input logic [15:0] b, input int sh,
                                         input bit rnd);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            int v = int'($signed(b[k*4 +: 4]));
            if (k == 3) s -= v * (1 << k);
            else        s += v * (1 << k);
        end
        if (rnd && sh > 0) s += 1 << (sh - 1);
        s = s >>> sh;
        if (s > 31)       return {1'b1, 6'h1F};
        else if (s < -32) return {1'b1, 6'h20};
        else              return {1'b0, 6'(s)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [3:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("in_ready timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [15:0] b,
                             input int gap_max);
        logic [6:0] e;
        for (int k = 0; k < 4; k++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            drive_beat(b[k*4 +: 4]);
            if (k < 3) chk({nm, " busy"}, 32'(busy), 1);
        end
        e = model(b, 0, RND);
        chk({nm, " out_valid"}, 32'(out_valid), 1);
        chk({nm, " out_data"}, 32'(out_data), 32'(e[5:0]));
        chk({nm, " sat_flag"}, 32'(sat_flag), 32'(e[6]));
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("take out_valid", 32'(out_valid), 0);
        chk("take in_ready", 32'(in_ready), 1);
    endtask

    typedef struct {
        logic [15:0] beats;
        logic [5:0]  exp;
        logic        sat;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  e;
        logic [15:0] rb;
        logic [5:0]  held;

        vt[0] = '{16'h1111, 6'h3F, 1'b0};
        vt[1] = '{16'h0777, 6'h1F, 1'b1};
        vt[2] = '{16'h8000, 6'h1F, 1'b1};
        vt[3] = '{16'h0888, 6'h20, 1'b1};
        vt[4] = '{16'h0000, 6'h00, 1'b0};
        vt[5] = '{16'hFFFF, 6'h01, 1'b0};
        vt[6] = '{16'h7000, 6'h20, 1'b1};
        vt[7] = '{16'h0003, 6'h03, 1'b0};

        #2;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst sat_flag", 32'(sat_flag), 0);
        chk("rst busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            e = model(vt[i].beats, 0, RND);
            chk("model vs table", 32'(e), 32'({vt[i].sat, vt[i].exp}));
            run_frame("table", vt[i].beats, 0);
            chk("table const data", 32'(out_data), 32'(vt[i].exp));
            chk("table const sat", 32'(sat_flag), 32'(vt[i].sat));
            take();
        end

        // backpressure: result held, beats ignored, next frame right away
        run_frame("bp", 16'h1111, 0);
        held = out_data;
        in_valid = 1'b1;
        in_data  = 4'h7;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp in_ready", 32'(in_ready), 0);
            chk("bp out_valid", 32'(out_valid), 1);
            chk("bp out_data", 32'(out_data), 32'(held));
            chk("bp busy", 32'(busy), 0);
        end
        in_valid = 1'b0;
        take();
        run_frame("after bp", 16'h0001, 0);
        take();

        // clear after two beats drops the partial sum and the clear-cycle beat
        drive_beat(4'h7);
        drive_beat(4'h7);
        chk("pre-clear busy", 32'(busy), 1);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 4'h7;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear busy", 32'(busy), 0);
        chk("clear out_valid", 32'(out_valid), 0);
        run_frame("post clear", 16'h0001, 0);
        chk("post clear value", 32'(out_data), 1);

        // clear while holding discards the pending result
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear hold out_valid", 32'(out_valid), 0);
        chk("clear hold out_data", 32'(out_data), 0);
        chk("clear hold in_ready", 32'(in_ready), 1);

        // asynchronous reset while a result is pending
        run_frame("pre reset", 16'h0777, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 0);
        chk("async out_data", 32'(out_data), 0);
        chk("async sat_flag", 32'(sat_flag), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // asynchronous reset mid-frame
        drive_beat(4'h5);
        drive_beat(4'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", 32'(busy), 0);
        chk("async mid out_valid", 32'(out_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_frame("post reset", 16'h0001, 0);
        chk("post reset value", 32'(out_data), 1);
        take();

        // SHIFT=1 instance: 3 -> 1 truncated, 2 rounded
        for (int k = 0; k < 4; k++) begin
            v1 = 1'b1;
            d1 = (k == 0) ? 4'h3 : 4'h0;
            chk("s1 in_ready", 32'(ir1), 1);
            tick();
        end
        v1 = 1'b0;
        e = model(16'h0003, 1, RND);
        chk("s1 out_valid", 32'(ov1), 1);
        chk("s1 out_data", 32'(od1), 32'(e[5:0]));
        chk("s1 const", 32'(od1), RND ? 2 : 1);
        chk("s1 sat", 32'(sf1), 0);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        chk("s1 release", 32'(ov1), 0);

        // random frames with idle gaps and random consumer delay
        for (int f = 0; f < 40; f++) begin
            rb = 16'($urandom);
            run_frame("rand", rb, 2);
            held = out_data;
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rand hold data", 32'(out_data), 32'(held));
                chk("rand hold valid", 32'(out_valid), 1);
            end
            take();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
